// File: rtl/citrus_fetch_pkg.sv
// Shared widths, halt encoding and the prefetch entry layout for the Citrus fetch unit.
package citrus_fetch_pkg;

   localparam int          FETCH_ADDR_W    = 16;
   localparam int          FETCH_DATA_W    = 32;
   localparam logic [31:0] FETCH_HALT_WORD = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t; flush empties it in one cycle.
module fetch_fifo
   import citrus_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  fetch_entry_t     wr_entry,
   output fetch_entry_t     rd_entry,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   fetch_entry_t     mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by plain overflow
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && push) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign count    = count_q;
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign rd_entry = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Citrus instruction fetch: drives the ROM address, prefetches into fetch_fifo, hands words to decode.
// Define CITRUS_FETCH_HALT_EN to stop fetching after a HALT_WORD is pushed.
// Valid/ready: an entry transfers on a rising edge where out_valid & out_ready are both high;
// out_valid never depends on out_ready, and redirect masks both valid and the transfer.
module instr_fetch_unit
   import citrus_fetch_pkg::*;
#(
   parameter int                ADDR_W    = FETCH_ADDR_W,
   parameter int                DATA_W    = FETCH_DATA_W,
   parameter int                DEPTH     = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [DATA_W-1:0] HALT_WORD = FETCH_HALT_WORD
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              fetch_halted
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              halted;
   logic              push, pop;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count_unused;
   fetch_entry_t      wr_entry, rd_entry;

   assign out_valid = ~fifo_empty & ~redirect;
   assign pop       = out_valid & out_ready;
   // A pop frees a slot in the same edge, so a full FIFO still fetches one word per cycle
   assign push      = ~redirect & ~halted & (~fifo_full | pop);

   always_comb begin
      wr_entry       = '0;
      wr_entry.pc    = fetch_pc_q;
      wr_entry.instr = rom_data;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect)  fetch_pc_d = redirect_pc;
      else if (push) fetch_pc_d = fetch_pc_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) fetch_pc_q <= RESET_PC;
      else     fetch_pc_q <= fetch_pc_d;
   end

`ifdef CITRUS_FETCH_HALT_EN
   logic halted_q, halted_d;

   always_comb begin
      halted_d = halted_q;
      if (redirect)                             halted_d = 1'b0;
      else if (push && (rom_data == HALT_WORD)) halted_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) halted_q <= 1'b0;
      else     halted_q <= halted_d;
   end

   assign halted = halted_q;
`else
   logic unused_halt_word;
   assign unused_halt_word = ^HALT_WORD;
   assign halted           = 1'b0;
`endif

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .push     (push),
      .pop      (pop),
      .wr_entry (wr_entry),
      .rd_entry (rd_entry),
      .count    (fifo_count_unused),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign rom_addr     = fetch_pc_q;
   assign out_instr    = rd_entry.instr;
   assign out_pc       = rd_entry.pc;
   assign fetch_halted = halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector tables, hand sequences and a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_ready = 1'b0;

  logic [15:0] rom_addr0, out_pc0, rom_addr1, out_pc1;
  logic [31:0] rom_data0, out_instr0, rom_data1, out_instr1;
  logic        out_valid0, fetch_halted0, out_valid1, fetch_halted1;

  logic        rom_mode = 1'b0;
  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = '0;

  int n_tests = 0;
  int n_fail = 0;

  // clock / reset block
  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid0),
    .out_ready(out_ready), .out_instr(out_instr0), .out_pc(out_pc0),
    .fetch_halted(fetch_halted0)
  );

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut1 (
    .clk(clk), .rst(rst), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid1),
    .out_ready(out_ready), .out_instr(out_instr1), .out_pc(out_pc1),
    .fetch_halted(fetch_halted1)
  );

  // combinational ROM models
  always_comb begin
    if (halt_en && rom_addr0 == halt_addr) rom_data0 = 32'hFFFF_FFFF;
    else if (rom_mode)                     rom_data0 = {rom_addr0, ~rom_addr0};
    else                                   rom_data0 = {16'h0000, rom_addr0};
  end

  always_comb begin
    if (halt_en && rom_addr1 == halt_addr) rom_data1 = 32'hFFFF_FFFF;
    else if (rom_mode)                     rom_data1 = {rom_addr1, ~rom_addr1};
    else                                   rom_data1 = {16'h0000, rom_addr1};
  end

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
    if (rom_mode) return {a, ~a};
    return {16'h0000, a};
  endfunction

  // scoreboard: expected FIFO contents plus fetch pointer and halt flag
  logic [15:0] exp_pc_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] m_pc = '0;
  logic        m_halted = 1'b0;
  bit          m_init = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [15:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    e_pc    = '0;
    e_instr = '0;
    e_valid = (exp_q.size() != 0) && !redirect;
    if (exp_q.size() != 0) begin
      e_pc    = exp_pc_q[0];
      e_instr = exp_q[0];
    end
    chk("model rom_addr", 32'(rom_addr0), 32'(m_pc));
    chk("model out_valid", 32'(out_valid0), 32'(e_valid));
    chk("model out_pc", 32'(out_pc0), 32'(e_pc));
    chk("model out_instr", out_instr0, e_instr);
    chk("model fetch_halted", 32'(fetch_halted0), 32'(m_halted));
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      exp_q.delete(); exp_pc_q.delete();
      m_pc = 16'h0000; m_halted = 1'b0; m_init = 1'b1;
    end else if (redirect) begin
      exp_q.delete(); exp_pc_q.delete();
      m_pc = redirect_pc; m_halted = 1'b0;
    end else begin
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
      if (!m_halted && exp_q.size() < DEPTH) begin
        w = rom_word(m_pc);
        exp_q.push_back(w);
        exp_pc_q.push_back(m_pc);
`ifdef CITRUS_FETCH_HALT_EN
        if (w == 32'hFFFF_FFFF) m_halted = 1'b1;
`endif
        m_pc = 16'(m_pc + 16'd1);
      end
    end
  endtask

  // driver tasks: inputs change just after the falling edge, outputs checked 1 ns later
  task automatic apply(input logic r, input logic rd, input logic [15:0] rp, input logic rdy);
    rst = r; redirect = rd; redirect_pc = rp; out_ready = rdy;
    #1;
    if (m_init) model_check();
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 16'h0, 1'b0); advance();
    apply(1'b1, 1'b0, 16'h0, 1'b0); advance();
  endtask

  typedef struct {
    bit          rst_before;
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] wrap_seq[4];

  initial begin
    vec_t v;

    // streaming with ready high: one word per cycle after a one-cycle fill
    for (int k = 0; k < 8; k++) begin
      v.rst_before = (k == 0);
      v.ready      = 1'b1;
      v.exp_addr   = 16'(k);
      v.exp_valid  = (k >= 1);
      v.exp_pc     = (k >= 1) ? 16'(k - 1) : 16'h0;
      tbl.push_back(v);
    end
    // 10 stalled cycles fill the FIFO, then pcs 0..4 drain back-to-back
    for (int k = 0; k < 15; k++) begin
      v.rst_before = (k == 0);
      v.ready      = (k >= 10);
      v.exp_valid  = (k >= 1);
      v.exp_addr   = (k < 10) ? 16'((k < 4) ? k : 4) : 16'(k - 6);
      v.exp_pc     = (k < 10) ? 16'h0 : 16'(k - 10);
      tbl.push_back(v);
    end
    wrap_seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      apply(1'b0, 1'b0, 16'h0, tbl[i].ready);
      chk("tbl rom_addr", 32'(rom_addr0), 32'(tbl[i].exp_addr));
      chk("tbl out_valid", 32'(out_valid0), 32'(tbl[i].exp_valid));
      chk("tbl out_pc", 32'(out_pc0), 32'(tbl[i].exp_pc));
      chk("tbl out_instr", out_instr0, {16'h0000, tbl[i].exp_pc});
      chk("tbl fetch_halted", 32'(fetch_halted0), 32'd0);
      advance();
    end

    // redirect with 3 buffered entries: two dead cycles, then the new stream only
    do_reset();
    for (int k = 0; k < 3; k++) begin apply(1'b0, 1'b0, 16'h0, 1'b0); advance(); end
    apply(1'b0, 1'b1, 16'h0100, 1'b1);
    chk("redir valid in redirect cycle", 32'(out_valid0), 32'd0);
    chk("redir addr before", 32'(rom_addr0), 32'h0003);
    advance();
    apply(1'b0, 1'b0, 16'h0, 1'b1);
    chk("redir valid next cycle", 32'(out_valid0), 32'd0);
    chk("redir rom_addr", 32'(rom_addr0), 32'h0100);
    advance();
    apply(1'b0, 1'b0, 16'h0, 1'b1);
    chk("redir first valid", 32'(out_valid0), 32'd1);
    chk("redir first pc", 32'(out_pc0), 32'h0100);
    chk("redir first instr", out_instr0, 32'h0000_0100);
    advance();
    apply(1'b0, 1'b0, 16'h0, 1'b1);
    chk("redir second pc", 32'(out_pc0), 32'h0101);
    advance();

    // RESET_PC near the top of the address space wraps silently
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 16'h0, 1'b1);
      if (k == 0) begin
        chk("wrap first addr", 32'(rom_addr1), 32'hFFFE);
        chk("wrap first valid", 32'(out_valid1), 32'd0);
      end else begin
        chk("wrap valid", 32'(out_valid1), 32'd1);
        chk("wrap out_pc", 32'(out_pc1), 32'(wrap_seq[k-1]));
        chk("wrap out_instr", out_instr1, {16'h0000, wrap_seq[k-1]});
      end
      advance();
    end

    // reset beats a simultaneous redirect
    apply(1'b1, 1'b1, 16'h0200, 1'b1);
    advance();
    apply(1'b0, 1'b0, 16'h0, 1'b0);
    chk("rst+redir valid", 32'(out_valid0), 32'd0);
    chk("rst+redir addr", 32'(rom_addr0), 32'h0000);
    chk("rst+redir addr dut1", 32'(rom_addr1), 32'hFFFE);
    chk("rst+redir out_pc", 32'(out_pc0), 32'h0000);
    advance();

`ifdef CITRUS_FETCH_HALT_EN
    halt_en = 1'b1; halt_addr = 16'h0005;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      apply(1'b0, 1'b0, 16'h0, 1'b1);
      if (k >= 1) chk("halt delivered pc", 32'(out_pc0), 32'(k - 1));
      if (k == 6) begin
        chk("halt flag", 32'(fetch_halted0), 32'd1);
        chk("halt addr", 32'(rom_addr0), 32'h0006);
        chk("halt word", out_instr0, 32'hFFFF_FFFF);
      end
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 16'h0, 1'b1);
      chk("halt idle valid", 32'(out_valid0), 32'd0);
      chk("halt held addr", 32'(rom_addr0), 32'h0006);
      advance();
    end
    apply(1'b0, 1'b1, 16'h0000, 1'b1); advance();
    apply(1'b0, 1'b0, 16'h0, 1'b1);
    chk("halt cleared", 32'(fetch_halted0), 32'd0);
    chk("halt restart addr", 32'(rom_addr0), 32'h0000);
    advance();
    apply(1'b0, 1'b0, 16'h0, 1'b1);
    chk("halt restart pc", 32'(out_pc0), 32'h0000);
    chk("halt restart valid", 32'(out_valid0), 32'd1);
    advance();
    halt_en = 1'b0;
`endif

    // randomized traffic against the reference model
    rom_mode = 1'b1;
    halt_en  = 1'b1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        r, rd, rdy;
      logic [15:0] rp;
      r   = ($urandom_range(0, 99) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rp  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                        : 16'($urandom);
      if (rd && $urandom_range(0, 1) == 1) halt_addr = 16'(rp + 16'($urandom_range(0, 6)));
      apply(r, rd, rp, rdy);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction ROM interface: drives the 16-bit word address into the combinational 32-bit ROM (rom64k) and captures the returned word.
- Buffers fetched words with their addresses in a small prefetch FIFO.
- Hands words to the Citrus decode stage over a valid/ready handshake.
- Supports branch/jump redirect with flush.

Parameters:
ADDR_W, 16, ROM word-address width.
DATA_W, 32, instruction word width.
DEPTH, 4, prefetch FIFO entries (power of two, >=2).
RESET_PC, 16'h0000, word address fetched first after reset.
HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch (optional feature only).

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
rom_addr  out  ADDR_W  word address to ROM, equals fetch_pc register.
rom_data  in  DATA_W  ROM read data, combinational from rom_addr, valid same cycle.
redirect  in  1  flush and restart fetch at redirect_pc.
redirect_pc  in  ADDR_W  new fetch word address.
out_valid  out  1  head entry available.
out_ready  in  1  decode accepts head entry.
out_instr  out  DATA_W  head instruction word.
out_pc  out  ADDR_W  word address of out_instr.
fetch_halted  out  1  fetch stopped on HALT_WORD; constant 0 without the macro.

Behaviour:
- Reset (clk edge with rst=1):
  - fetch_pc=RESET_PC, FIFO count=0, head/tail pointers=0, halted=0.
  - Outputs: rom_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_halted=0.
  - rst has priority over redirect and all handshakes.
  - rst asserted mid-operation discards all buffered entries.
- pop = out_valid & out_ready & ~redirect.
- push = ~redirect & ~halted & ((count != DEPTH) | pop). Simultaneous push and pop when full is allowed, giving one instruction/cycle sustained throughput.
- On push:
  - Entry {rom_addr, rom_data} is written at tail.
  - fetch_pc increments by 1, modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000 with no flag).
- count updates +1 on push only, -1 on pop only, unchanged on both or neither.
- out_valid = (count != 0) & ~redirect. out_instr/out_pc are driven from the head entry, or 0 when count==0.
- Redirect (priority over push and pop):
  - FIFO flushed (count=0, pointers=0) and fetch_pc=redirect_pc.
  - halted=0.
  - A handshake on out_ready that same cycle is ignored.
- Latency:
  - Redirect sampled at edge N; rom_addr=redirect_pc during cycle N+1.
  - That word is pushed at edge N+1 and out_valid=1 in cycle N+2.
  - Same 1-cycle fill latency after reset release.
- Backpressure: with out_ready=0, fetch fills DEPTH entries and then holds fetch_pc. rom_addr stays stable while full.
- Empty with out_ready=1: out_valid=0, no pop. There is no combinational ROM-to-out bypass.

Optional Feature:
- Macro: CITRUS_FETCH_HALT_EN.
- With the macro:
  - Pushing a word equal to HALT_WORD sets halted at that edge.
  - The halt word itself is still pushed and delivered.
  - fetch_pc is held at the HALT_WORD address + 1 with no further pushes.
  - fetch_halted=halted. Only redirect or rst clears halted.
- Without the macro: halted logic is absent, fetch_halted is tied 0, and HALT_WORD is unused.

Decomposition:
- Package citrus_fetch_pkg holds:
  - ADDR_W/DATA_W defaults and HALT_WORD.
  - fetch_entry_t struct {pc[ADDR_W], instr[DATA_W]}.
- Sub-module fetch_fifo is a synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty outputs.
- Top level keeps fetch_pc, push/pop/redirect arbitration and halt logic.

Test Plan:
- Reset then out_ready=1, ROM with word[i]=i:
  - rom_addr 0,1,2… per cycle.
  - out_valid first high 1 cycle after reset release, with out_pc=0, out_instr=0.
  - One entry accepted per cycle thereafter.
- out_ready=0 for 10 cycles after reset:
  - count saturates at 4 and rom_addr holds 16'h0004.
  - Then out_ready=1 delivers pcs 0..3 back-to-back, and fetch resumes at 4 without a bubble.
- Redirect to 16'h0100 while the FIFO holds 3 entries and out_ready=1:
  - out_valid=0 in the redirect cycle and the next cycle.
  - Next delivered out_pc=16'h0100, with no stale entries.
- RESET_PC=16'hFFFE: delivered out_pc sequence is FFFE, FFFF, 0000, 0001.
- rst asserted mid-stream with redirect high: next cycle out_valid=0 and rom_addr=RESET_PC (redirect ignored).
- With CITRUS_FETCH_HALT_EN, HALT_WORD at address 5:
  - pcs 0..5 are delivered, then fetch_halted=1 and rom_addr stays 6.
  - Redirect to 0 clears fetch_halted and fetch restarts at 0.
